// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream input and imem write-port bundle for the boot loader.
//   rx_data/rx_valid/rx_ready : valid/ready byte stream from host/UART.
//   imem_addr/imem_wdata/imem_wren : one-cycle-per-word imem write port.
//   modport slave  : used by the loader (consumes stream, drives imem).
//   modport master : used by the byte source / memory side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  imem_wren;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_addr, imem_wdata, imem_wren
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_addr, imem_wdata, imem_wren
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the instruction memory. Receives a 2-byte
//   big-endian word count N followed by N big-endian 32-bit words, writes
//   them to imem addresses 0..N-1 and holds the CPU in reset until done.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   start   : one-cycle pulse, begins a load from IDLE/DONE/ERR
//   bus     : byte stream in + imem write port (imem_loader_if.slave)
//   cpu_rst : processor reset hold, active-high
//   busy    : load in progress
//   done    : image loaded, processor released
//   err     : illegal length received, sticky until next start
//
// state  | meaning
// IDLE   | after reset, waiting for start, CPU held
// LEN_HI | waiting for N[15:8]
// LEN_LO | waiting for N[7:0], length check
// BYTE   | assembling a word from 4 stream bytes
// WRITE  | single imem write cycle, stream stalled
// DONE   | image loaded, CPU released
// ERR    | bad length, CPU held
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 2**ADDR_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  imem_loader_if.slave bus,
  output logic cpu_rst,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, BYTE, WRITE, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t                state_q, state_n;
  logic [15:0]           len_q, len_n;
  // One bit wider than the address so N == MAX_WORDS completes without wrap.
  logic [ADDR_WIDTH:0]   word_q, word_n;
  logic [ADDR_WIDTH:0]   word_inc;
  logic [1:0]            byte_q, byte_n;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
  logic [DATA_WIDTH-1:0] assembled;
  logic [15:0]           len_lo_val;

  logic                  rx_ready_q, rx_ready_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                  wren_q, wren_n;
  logic                  cpu_rst_n, busy_n, done_n, err_n;

  logic                  accept;

  assign accept     = bus.rx_valid & rx_ready_q;
  assign word_inc   = word_q + 1'b1;
  assign assembled  = {shreg_q[DATA_WIDTH-9:0], bus.rx_data};
  assign len_lo_val = {len_q[15:8], bus.rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      rx_ready_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_n;
      len_q      <= len_n;
      word_q     <= word_n;
      byte_q     <= byte_n;
      shreg_q    <= shreg_n;
      rx_ready_q <= rx_ready_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      wren_q     <= wren_n;
      cpu_rst    <= cpu_rst_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    len_n   = len_q;
    word_n  = word_q;
    byte_n  = byte_q;
    shreg_n = shreg_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    wren_n  = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_n = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          len_n   = {bus.rx_data, 8'h00};
          state_n = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_n  = len_lo_val;
          word_n = '0;
          byte_n = '0;
          if (len_lo_val == 16'd0)
            state_n = DONE;
          else if ({1'b0, len_lo_val} > MAX_LEN)
            state_n = ERR;
          else
            state_n = BYTE;
        end
      end
      BYTE: begin
        if (accept) begin
          shreg_n = assembled;
          byte_n  = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            // Write outputs are registered, so they are valid during WRITE.
            wren_n  = 1'b1;
            addr_n  = word_q[ADDR_WIDTH-1:0];
            wdata_n = assembled;
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        word_n = word_inc;
        byte_n = '0;
        if (16'(word_inc) == len_q)
          state_n = DONE;
        else
          state_n = BYTE;
      end
      default: state_n = IDLE;
    endcase

    // Status outputs are decoded from the next state and registered.
    rx_ready_n = (state_n == LEN_HI) || (state_n == LEN_LO) || (state_n == BYTE);
    busy_n     = rx_ready_n || (state_n == WRITE);
    done_n     = (state_n == DONE);
    err_n      = (state_n == ERR);
    cpu_rst_n  = (state_n != DONE);
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.imem_wren  = wren_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_rst, busy, done, err;

  imem_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  imem_loader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  logic [11:0] last_addr;
  logic [31:0] last_data;
  logic [43:0] sb_q[$];
  int exp_addr;

  // Monitor: every imem write is popped from the scoreboard and compared.
  always @(posedge clk) begin
    logic [43:0] e;
    #1;
    if (bus.imem_wren === 1'b1) begin
      n_writes++;
      last_addr = bus.imem_addr;
      last_data = bus.imem_wdata;
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_write addr=%h data=%h, required no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = sb_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== e)
          $display("FAIL write addr/data=%h/%h, required %h/%h", bus.imem_addr, bus.imem_wdata, e[43:32], e[31:0]);
        else n_pass++;
      end
      n_checks++;
      if (bus.rx_ready !== 1'b0) $display("FAIL rx_ready_in_write got=%b, required 0", bus.rx_ready);
      else n_pass++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL byte_accept_timeout byte=%h rx_ready=%b, required 1", b, bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'hxx;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    sb_q.push_back({12'(exp_addr), w});
    exp_addr++;
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic check_finished(input string name, input int exp_writes, input int w0);
    n_checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_done done/cpu_rst/busy=%b%b%b, required 100", name, done, cpu_rst, busy);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_writes - w0 !== exp_writes || sb_q.size() != 0)
      $display("FAIL %s_write_count got=%0d pending=%0d, required %0d pending=0", name, n_writes - w0, sb_q.size(), exp_writes);
    else n_pass++;
  endtask

  task automatic load_two_words(input string name, input int gap);
    int w0 = n_writes;
    pulse_start();
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_word(32'h20010005, gap);
    send_word(32'hAC22000A, 0);
    // Now in the last WRITE cycle: CPU must still be held.
    n_checks++;
    if (bus.imem_wren !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0)
      $display("FAIL %s_last_write wren/cpu_rst/done=%b%b%b, required 110", name, bus.imem_wren, cpu_rst, done);
    else n_pass++;
    @(negedge clk);
    check_finished(name, 2, w0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    repeat (2) @(negedge clk);
    start = 1'b1;             // start with rst asserted is ignored
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_rst, bus.rx_ready, busy, done, err, bus.imem_wren} !== 6'b100000 || bus.imem_addr !== 12'd0 || bus.imem_wdata !== 32'd0)
      $display("FAIL reset_values cpu_rst/rdy/busy/done/err/wren=%b%b%b%b%b%b addr=%h, required 100000 addr=000",
               cpu_rst, bus.rx_ready, busy, done, err, bus.imem_wren, bus.imem_addr);
    else n_pass++;
    pulse_start();
    n_checks++;
    if (bus.rx_ready !== 1'b1 || busy !== 1'b1 || cpu_rst !== 1'b1)
      $display("FAIL start_response rdy/busy/cpu_rst=%b%b%b, required 111", bus.rx_ready, busy, cpu_rst);
    else n_pass++;
  endtask

  task automatic test_normal();
    load_two_words("normal", 0);   // start in LEN_HI is ignored
  endtask

  task automatic test_stalled();
    load_two_words("stalled", 2);  // rx_valid pattern 1,0,0,1
  endtask

  task automatic test_len_edges();
    int w0 = n_writes;
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || cpu_rst !== 1'b1)
      $display("FAIL restart_from_done done/cpu_rst=%b%b, required 01", done, cpu_rst);
    else n_pass++;
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    n_checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || bus.rx_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL len_too_big err/cpu_rst/rdy/busy/done=%b%b%b%b%b, required 11000", err, cpu_rst, bus.rx_ready, busy, done);
    else n_pass++;
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL err_clear err/busy=%b%b, required 01", err, busy);
    else n_pass++;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_finished("len_zero", 0, w0);
  endtask

  task automatic test_full_image();
    int w0 = n_writes;
    pulse_start();
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4096; k++) send_word(32'(k), 0);
    @(negedge clk);
    check_finished("full", 4096, w0);
    n_checks++;
    if (last_addr !== 12'hFFF || last_data !== 32'h00000FFF)
      $display("FAIL full_last_write addr=%h data=%h, required fff/00000fff", last_addr, last_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int w0 = n_writes;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({cpu_rst, busy, bus.rx_ready, done, err, bus.imem_wren} !== 6'b100000)
      $display("FAIL mid_reset cpu_rst/busy/rdy/done/err/wren=%b%b%b%b%b%b, required 100000",
               cpu_rst, busy, bus.rx_ready, done, err, bus.imem_wren);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_writes - w0 !== 1 || sb_q.size() != 0)
      $display("FAIL mid_reset_writes got=%0d, required 1", n_writes - w0);
    else n_pass++;
    w0 = n_writes;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hDEADBEEF, 0);
    @(negedge clk);
    check_finished("after_reset", 1, w0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stalled();
    test_len_edges();
    test_full_image();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
